// File: rtl/apb_pkg.sv
// ============================================================================
//  Module   : apb_pkg
//  Purpose  : Shared types and widths for the APB memory completer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package apb_pkg;

  localparam int APB_DATA_W = 8;
  localparam int APB_ADDR_W = 9;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } apb_slv_state_t;

endpackage

`default_nettype wire

// File: rtl/apb_mem_array.sv
// ============================================================================
//  Module   : apb_mem_array
//  Purpose  : Storage array with per-location written flags, one synchronous
//             write port and one asynchronous read port.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module apb_mem_array
  import apb_pkg::*;
#(
  parameter int DATA_W = APB_DATA_W,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_valid;

  // Data contents are deliberately left unreset; r_valid guards every read.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (we) begin
      r_valid[waddr] <= 1'b1;
    end
  end

  assign rdata  = r_mem[raddr];
  assign rvalid = r_valid[raddr];

endmodule

`default_nettype wire

// File: rtl/apb_mem_slave.sv
// ============================================================================
//  Module   : apb_mem_slave
//  Purpose  : APB3 completer fronting a byte-wide memory, with programmable
//             wait states and PSLVERR for out-of-range or unwritten reads.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W - 1,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = 4;

  apb_slv_state_t     r_state;
  apb_slv_state_t     w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;

  logic              w_ready;
  logic              w_in_range;
  logic              w_err;
  logic              w_we;
  logic [DATA_W-1:0] w_rdata;
  logic              w_rvalid;

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; an access phase seen from IDLE had no setup and is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = c_CNT_W'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        if (!PSEL) begin
          w_state_nxt = IDLE;
        end else if (PENABLE) begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    w_ready    = (r_state == WAIT) && PSEL && PENABLE && (r_cnt == '0);
    w_in_range = ({1'b0, PADDR} < (ADDR_W + 1)'(DEPTH));
    w_err      = w_ready && (!w_in_range || (!PWRITE && !w_rvalid));
    w_we       = w_ready && PWRITE && w_in_range && !PRESET;
    PREADY     = w_ready;
    PSLVERR    = w_err;
    PRDATA     = '0;
    if (w_ready && !PWRITE && !w_err) begin
      PRDATA = w_rdata;
    end
  end

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (c_IDX_W)
  ) u_mem (
    .clk    (PCLK),
    .rst    (PRESET),
    .we     (w_we),
    .waddr  (PADDR[c_IDX_W-1:0]),
    .wdata  (PWDATA),
    .raddr  (PADDR[c_IDX_W-1:0]),
    .rdata  (w_rdata),
    .rvalid (w_rvalid)
  );

endmodule

`default_nettype wire
